// File: rtl/load_store_unit.sv
// Load/store unit: aligns and extends loads, lane-replicates stores, and flags misaligned or illegal accesses.
// Optional feature macro: LSU_TIMEOUT_EN (bounds the wait for mem_ack to TIMEOUT_CYCLES ACCESS cycles).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWr,
  input  logic [2:0]  MemOp,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  // Byte-enable pattern for a given size (MemOp[2:1]) and byte offset.
  function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the access could target.
  function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down and sign- or zero-extend it.
  function automatic logic [31:0] load_f(input logic [2:0] op, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0] lane;
    logic [31:0] r;
    lane = word >> {off, 3'b000};
    case (op)
      3'b000:  r = {{24{lane[7]}}, lane[7:0]};
      3'b001:  r = {24'h000000, lane[7:0]};
      3'b010:  r = {{16{lane[15]}}, lane[15:0]};
      3'b011:  r = {16'h0000, lane[15:0]};
      3'b100:  r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t      state_r, state_s;
  logic        req_ready_r, req_ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic [31:0] rdata_r, rdata_s;
  logic        err_r, err_s;
  logic        mem_req_r, mem_req_s;
  logic        mem_we_r, mem_we_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [3:0]  mem_be_r, mem_be_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic [2:0]  op_r, op_s;
  logic [1:0]  off_r, off_s;
  logic        wr_r, wr_s;
  logic        illegal_s;
  logic        misaligned_s;

`ifdef LSU_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] cnt_r, cnt_s;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

  // Classify the incoming request: opcodes 101/110/111 are illegal, sub-word alignment is checked by size.
  always_comb begin
    illegal_s    = MemOp[2] & (MemOp[1] | MemOp[0]);
    misaligned_s = ((MemOp[2:1] == 2'b01) & addr[0]) |
                   ((MemOp[2:1] == 2'b10) & (addr[1:0] != 2'b00));
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s      = state_r;
    resp_valid_s = 1'b0;
    rdata_s      = rdata_r;
    err_s        = err_r;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_be_s     = mem_be_r;
    mem_wdata_s  = mem_wdata_r;
    op_s         = op_r;
    off_s        = off_r;
    wr_s         = wr_r;
`ifdef LSU_TIMEOUT_EN
    cnt_s        = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          op_s  = MemOp;
          off_s = addr[1:0];
          wr_s  = MemWr;
          if (illegal_s | misaligned_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            err_s        = 1'b1;
            rdata_s      = 32'h0000_0000;
          end else begin
            state_s     = ACCESS;
            mem_req_s   = 1'b1;
            mem_we_s    = MemWr;
            mem_addr_s  = {addr[31:2], 2'b00};
            // Loads read the whole word, so enables are only driven for stores.
            mem_be_s    = MemWr ? be_f(MemOp[2:1], addr[1:0]) : 4'b0000;
            mem_wdata_s = wdata_f(MemOp[2:1], wdata);
`ifdef LSU_TIMEOUT_EN
            cnt_s       = 32'h0000_0000;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          err_s        = 1'b0;
          rdata_s      = wr_r ? 32'h0000_0000 : load_f(op_r, off_r, mem_rdata);
          mem_req_s    = 1'b0;
          mem_we_s     = 1'b0;
          mem_be_s     = 4'b0000;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_r == TIMEOUT_LAST) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          err_s        = 1'b1;
          rdata_s      = 32'h0000_0000;
          mem_req_s    = 1'b0;
          mem_we_s     = 1'b0;
          mem_be_s     = 4'b0000;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
`else
        else begin
          state_s = ACCESS;
        end
`endif
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        mem_be_s  = 4'b0000;
      end
    endcase
    req_ready_s = (state_s == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      op_r         <= 3'b000;
      off_r        <= 2'b00;
      wr_r         <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_r        <= 32'h0000_0000;
`endif
    end else begin
      state_r      <= state_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      rdata_r      <= rdata_s;
      err_r        <= err_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_be_r     <= mem_be_s;
      mem_wdata_r  <= mem_wdata_s;
      op_r         <= op_s;
      off_r        <= off_s;
      wr_r         <= wr_s;
`ifdef LSU_TIMEOUT_EN
      cnt_r        <= cnt_s;
`endif
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign rdata      = rdata_r;
  assign err        = err_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs driven and outputs sampled on the falling edge.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWr;
  logic [2:0]  MemOp;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec;
  int n_err;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .MemWr(MemWr), .MemOp(MemOp),
    .resp_valid(resp_valid), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single rising edge, then withdraw it.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic [2:0] op);
    req_valid = 1'b1;
    addr      = a;
    wdata     = d;
    MemWr     = wr;
    MemOp     = op;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0; MemWr = 1'b0;
    MemOp = 3'b000; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata_err", {rdata[30:0], err}, 32'h0);
    check("rst_memctl", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // lb at 0x1003, immediate ack
    issue(32'h0000_1003, 32'h0, 1'b0, 3'b000);
    check("lb_req", {30'h0, mem_req, req_ready}, 32'h2);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_be_we", {27'h0, mem_we, mem_be}, 32'h0);
    check("lb_noresp", {31'h0, resp_valid}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("lb_resp", {30'h0, resp_valid, err}, 32'h2);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    check("lb_reqdrop", {30'h0, mem_req, req_ready}, 32'h0);
    @(negedge clk);
    check("lb_idle", {30'h0, resp_valid, req_ready}, 32'h1);

    // lhu at 0x2002 with 3 wait states; a stray request during ACCESS must be ignored
    issue(32'h0000_2002, 32'h0, 1'b0, 3'b011);
    for (int i = 0; i < 4; i++) begin
      check("lhu_req", {31'h0, mem_req}, 32'h1);
      check("lhu_addr", mem_addr, 32'h0000_2000);
      check("lhu_noresp", {31'h0, resp_valid}, 32'h0);
      req_valid = (i < 3); addr = 32'h0000_7777; MemOp = 3'b100; mem_rdata = 32'h1111_1111;
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    check("lhu_resp", {30'h0, resp_valid, err}, 32'h2);
    check("lhu_rdata", rdata, 32'h0000_BEEF);
    // ack while idle must not produce a response; rdata holds
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack", {30'h0, resp_valid, mem_req}, 32'h0);
    check("lhu_hold", rdata, 32'h0000_BEEF);

    // lh at 0x0, signed half
    issue(32'h0000_0000, 32'h0, 1'b0, 3'b010);
    mem_ack = 1'b1; mem_rdata = 32'h1234_8001;
    @(negedge clk);
    mem_ack = 1'b0;
    check("lh_rdata", rdata, 32'hFFFF_8001);
    @(negedge clk);

    // misaligned lw: error on the very next cycle, no memory access
    issue(32'h0000_0005, 32'h0, 1'b0, 3'b100);
    check("mis_resp", {29'h0, resp_valid, err, mem_req}, 32'h6);
    check("mis_rdata", rdata, 32'h0);
    @(negedge clk);
    check("mis_after", {29'h0, resp_valid, mem_req, req_ready}, 32'h1);

    // illegal MemOp 110
    issue(32'h0000_0000, 32'h0, 1'b0, 3'b110);
    check("ill_resp", {29'h0, resp_valid, err, mem_req}, 32'h6);
    @(negedge clk);

    // sb at 0x10
    issue(32'h0000_0010, 32'h1234_56AB, 1'b1, 3'b000);
    check("sb_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h31);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_addr", mem_addr, 32'h0000_0010);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("sb_resp", {30'h0, resp_valid, err}, 32'h2);
    check("sb_rdata", rdata, 32'h0);
    check("sb_wedrop", {30'h0, mem_we, mem_req}, 32'h0);
    @(negedge clk);

    // sh at 0x12
    issue(32'h0000_0012, 32'h0000_CAFE, 1'b1, 3'b010);
    check("sh_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h3C);
    check("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
    check("sh_addr", mem_addr, 32'h0000_0010);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("sh_resp", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);

    // reset during ACCESS discards the transaction
    issue(32'h0000_0040, 32'h0, 1'b0, 3'b100);
    check("rstmid_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_state", {29'h0, mem_req, req_ready, resp_valid}, 32'h2);
    @(negedge clk);
    check("rstmid_noresp", {31'h0, resp_valid}, 32'h0);
    issue(32'h0000_0044, 32'h0, 1'b0, 3'b100);
    check("post_rst_addr", mem_addr, 32'h0000_0044);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("post_rst_resp", {30'h0, resp_valid, err}, 32'h2);
    check("post_rst_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);

`ifdef LSU_TIMEOUT_EN
    // no ack: timeout after 4 ACCESS cycles
    issue(32'h0000_0080, 32'h0, 1'b0, 3'b100);
    for (int i = 0; i < 4; i++) begin
      check("to_wait", {30'h0, mem_req, resp_valid}, 32'h2);
      @(negedge clk);
    end
    check("to_resp", {29'h0, resp_valid, err, mem_req}, 32'h6);
    check("to_rdata", rdata, 32'h0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the decoded load/store controls (MemWr, MemOp) produced by instruction decode.
- Accepts one request per transaction: effective address, store data and control. Drives a word-wide data-memory port with byte enables.
- Aligns and sign- or zero-extends load data; reports misaligned or illegal accesses.
- Sits between the ALU result/register file and the data memory.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ack. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE
- addr  input  32  byte address (rs1+imm)
- wdata  input  32  store data (rs2)
- MemWr  input  1  1=store, 0=load
- MemOp  input  3  000 byte signed, 001 byte unsigned, 010 half signed, 011 half unsigned, 100 word
- resp_valid  output  1  one-cycle completion pulse
- rdata  output  32  extended load result; 0 for stores and errors
- err  output  1  valid with resp_valid: misaligned, illegal MemOp or timeout
- mem_req  output  1  memory access request
- mem_we  output  1  write strobe
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  memory completes access this cycle
- mem_rdata  input  32  read word, valid when mem_ack=1

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, rdata=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- A request is accepted when req_valid & req_ready. addr, wdata, MemWr and MemOp are latched that cycle. Inputs are ignored outside IDLE.
- Size is MemOp[2:1]: 00 byte, 01 half, 10 word. MemOp[0]=1 selects unsigned. For stores MemOp[0] is ignored.
- Illegal MemOp: 101, 110, 111.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=00.
- State machine:
  - IDLE -> ACCESS on accept when the request is legal and aligned.
  - IDLE -> RESP on accept when the request is illegal or misaligned. Set err=1; no memory access.
  - ACCESS: hold mem_req=1 and stable mem_* signals until mem_ack. On the mem_ack cycle capture mem_rdata, then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready stays 0 in RESP.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 0011 for addr[1]=0, 1100 for addr[1]=1
  - word: 1111
- mem_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- mem_we = latched MemWr during ACCESS; 0 otherwise.
- Load extract: lane = mem_rdata >> (8*addr[1:0]). Byte uses bits [7:0], half uses [15:0]. Extend with bit 7 or bit 15 when signed; zero-extend when unsigned.
- Latency:
  - Accept at cycle T gives mem_req at T+1.
  - With mem_ack at T+1+W, resp_valid occurs at T+2+W (minimum T+2).
  - Error path: resp_valid at T+1.
  - Next accept is possible at the cycle after RESP.
- mem_ack outside ACCESS is ignored.
- Reset mid-transaction returns to IDLE next edge. mem_req drops immediately and the response is discarded.
- rdata and err hold their values until the next resp_valid.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, go to RESP with err=1, rdata=0, and deassert mem_req.
  - mem_ack on the same cycle as the timeout wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Load lb, addr=0x1003, mem_rdata=0x80FF_1234, ack after 0 waits -> mem_addr=0x1000, mem_be=0000 (read), resp_valid at T+2, rdata=0xFFFF_FF80, err=0.
- Load lhu, addr=0x2002, mem_rdata=0xBEEF_0000, ack after 3 waits -> rdata=0x0000_BEEF, resp_valid at T+5, mem_req held stable 4 cycles.
- Store sb, addr=0x10, wdata=0x1234_56AB -> mem_we=1, mem_be=0001, mem_wdata=0xABAB_ABAB; store sh, addr=0x12, wdata=0xCAFE -> mem_be=1100, mem_wdata=0xCAFE_CAFE.
- Misaligned lw at addr=0x5, and MemOp=110 -> resp_valid at T+1, err=1, rdata=0, mem_req never asserted.
- Reset asserted during ACCESS before mem_ack -> next cycle mem_req=0, req_ready=1, no resp_valid. A later request completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> err=1 with resp_valid after 4 ACCESS cycles, mem_req=0 in RESP.
